hdmi_timing: RTL and testbench

Video timing generator that drives the `dd1` input of the HDMI encoder. It runs horizontal and vertical counters and issues pixel-fetch requests to the pixel source. Returned RGB is aligned with delayed DE/HSYNC/VSYNC into the packed 27-bit `{R,G,B,DE,HSYNC,VSYNC}` word. The blanking geometry leaves the encoder room for its preambles, guard bands and post-HSYNC data islands.

---
 rtl/hdmi_timing.sv | 104 ++++++++++
 tb/tb_hdmi_timing.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_timing.sv
// hdmi_timing: 720p-style video timing generator feeding the HDMI encoder.
// Ports: clk/rst/run in; px_req/px_x/px_y out, px_rgb in; dd1/frame_start out.
module hdmi_timing #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int LAT      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        px_req,
  output logic [11:0] px_x,
  output logic [11:0] px_y,
  input  logic [23:0] px_rgb,
  output logic [26:0] dd1,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = LAT * 4;

  localparam logic [11:0] HA   = 12'(H_ACTIVE);
  localparam logic [11:0] HS0  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS1  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] HMAX = 12'(H_TOTAL - 1);
  localparam logic [11:0] VA   = 12'(V_ACTIVE);
  localparam logic [11:0] VS0  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS1  = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] VMAX = 12'(V_TOTAL - 1);

  logic [11:0]   h_q, h_d;
  logic [11:0]   v_q, v_d;
  logic [DW-1:0] dl_q, dl_d;
  logic [26:0]   dd1_q, dd1_d;
  logic          fs_q, fs_d;

  logic       de, hs, vs, fs;
  logic       vs_on, vs_off;
  logic [3:0] tap;
  logic [3:0] dl_top;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!run) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == HMAX) begin
      h_d = '0;
      v_d = (v_q == VMAX) ? '0 : v_q + 12'd1;
    end else begin
      h_d = h_q + 12'd1;
    end
  end

  // VSYNC edges are pinned to the HSYNC leading-edge column so the
  // encoder sees both syncs change on the same clock.
  assign vs_on  = (v_q > VS0) | ((v_q == VS0) & (h_q >= HS0));
  assign vs_off = (v_q > VS1) | ((v_q == VS1) & (h_q >= HS0));

  assign de = (h_q < HA) & (v_q < VA);
  assign hs = (h_q >= HS0) & (h_q < HS1);
  assign vs = vs_on & ~vs_off;
  assign fs = (h_q == 12'd0) & (v_q == 12'd0);

  assign px_req = de & run & ~rst;
  assign px_x   = px_req ? h_q : '0;
  assign px_y   = px_req ? v_q : '0;

  // Idle timing feeds zeros so the output drains to blank.
  assign tap    = run ? {de, hs, vs, fs} : 4'h0;
  assign dl_d   = DW'({dl_q, tap});
  assign dl_top = dl_q[DW-1 -: 4];

  assign dd1_d = {dl_top[3] ? px_rgb : 24'h0, dl_top[3:1]};
  assign fs_d  = dl_top[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q   <= '0;
      v_q   <= '0;
      dl_q  <= '0;
      dd1_q <= '0;
      fs_q  <= 1'b0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      dl_q  <= dl_d;
      dd1_q <= dd1_d;
      fs_q  <= fs_d;
    end
  end

  assign dd1         = dd1_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_hdmi_timing.sv
// tb_hdmi_timing: small-geometry and 720p instances checked against a
// position-based reference model plus hand-computed literal values.
module tb_hdmi_timing;

  typedef struct {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
  } geom_t;

  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a[2] = '{1'b1, 1'b1};
  logic        run_a[2] = '{1'b1, 1'b1};
  logic        req_a[2];
  logic [11:0] x_a[2];
  logic [11:0] y_a[2];
  logic [23:0] rgb_a[2];
  logic [26:0] dd_a[2];
  logic        fs_a[2];

  hdmi_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .LAT(LAT)
  ) dut_s (
    .clk(clk), .rst(rst_a[0]), .run(run_a[0]),
    .px_req(req_a[0]), .px_x(x_a[0]), .px_y(y_a[0]),
    .px_rgb(rgb_a[0]), .dd1(dd_a[0]), .frame_start(fs_a[0])
  );

  hdmi_timing #(.LAT(LAT)) dut_l (
    .clk(clk), .rst(rst_a[1]), .run(run_a[1]),
    .px_req(req_a[1]), .px_x(x_a[1]), .px_y(y_a[1]),
    .px_rgb(rgb_a[1]), .dd1(dd_a[1]), .frame_start(fs_a[1])
  );

  // Pixel source: coordinate pattern returned LAT clocks after the request.
  logic [23:0] src[2][LAT];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      src[k][0] <= {x_a[k][7:0], y_a[k][7:0], 8'hA5};
      for (int i = 1; i < LAT; i++) src[k][i] <= src[k][i-1];
    end
  end
  assign rgb_a[0] = src[0][LAT-1];
  assign rgb_a[1] = src[1][LAT-1];

  function automatic geom_t gk(int k);
    geom_t g;
    if (k == 0) g = '{8, 2, 2, 4, 3, 1, 1, 1};
    else        g = '{1280, 110, 40, 220, 720, 5, 5, 20};
    return g;
  endfunction

  function automatic int line_len(geom_t g);
    return g.ha + g.hf + g.hs + g.hb;
  endfunction

  function automatic int frame_len(geom_t g);
    return line_len(g) * (g.va + g.vf + g.vs + g.vb);
  endfunction

  // {rgb, de, hs, vs, fs} for linear frame position pos.
  function automatic logic [27:0] req_word(geom_t g, int pos);
    int ht, h, v, p0, p1;
    logic de, hsb, vsb;
    logic [23:0] rgb;
    ht  = line_len(g);
    h   = pos % ht;
    v   = pos / ht;
    de  = (h < g.ha) && (v < g.va);
    hsb = (h >= g.ha + g.hf) && (h < g.ha + g.hf + g.hs);
    p0  = (g.va + g.vf) * ht + g.ha + g.hf;
    p1  = p0 + g.vs * ht;
    vsb = (pos >= p0) && (pos < p1);
    rgb = de ? {h[7:0], v[7:0], 8'hA5} : 24'h0;
    return {rgb, de, hsb, vsb, (pos == 0)};
  endfunction

  int          cyc = 0;
  int          wp  = 16;
  int          pos[2] = '{default: 0};
  bit          hr[2][16] = '{default: 1'b1};
  logic [27:0] hw[2][16] = '{default: 28'h0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      hr[k][wp % 16] <= rst_a[k];
      hw[k][wp % 16] <= (rst_a[k] || !run_a[k]) ? 28'h0
                        : req_word(gk(k), pos[k]);
      pos[k] <= (rst_a[k] || !run_a[k]) ? 0
                : (pos[k] + 1) % frame_len(gk(k));
    end
    wp  <= wp + 1;
    cyc <= cyc + 1;
  end

  // Output edge log: 0 de rise, 1 de fall, 2 hs rise, 3 hs fall,
  // 4 vs rise, 5 vs fall, 6 frame_start.
  int       ev[2][7][64];
  int       ne[2][7] = '{default: 0};
  logic [3:0] pv[2] = '{default: 4'h0};

  always @(negedge clk) begin
    if (cyc >= 2) begin
      for (int k = 0; k < 2; k++) begin
        logic [3:0] cur;
        cur = {dd_a[k][2:0], fs_a[k]};
        for (int b = 0; b < 3; b++) begin
          if (cur[3-b] && !pv[k][3-b] && ne[k][2*b] < 64) begin
            ev[k][2*b][ne[k][2*b]] <= cyc;
            ne[k][2*b] <= ne[k][2*b] + 1;
          end
          if (!cur[3-b] && pv[k][3-b] && ne[k][2*b+1] < 64) begin
            ev[k][2*b+1][ne[k][2*b+1]] <= cyc;
            ne[k][2*b+1] <= ne[k][2*b+1] + 1;
          end
        end
        if (cur[0] && ne[k][6] < 64) begin
          ev[k][6][ne[k][6]] <= cyc;
          ne[k][6] <= ne[k][6] + 1;
        end
        pv[k] <= cur;
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_compare();
    for (int k = 0; k < 2; k++) begin
      geom_t       g;
      int          ht;
      logic [27:0] w, e;
      logic        er, clr;
      logic [11:0] ex, ey;
      logic [52:0] act, exp;
      g   = gk(k);
      ht  = line_len(g);
      w   = req_word(g, pos[k]);
      er  = !rst_a[k] && run_a[k] && w[3];
      ex  = er ? 12'(pos[k] % ht) : 12'd0;
      ey  = er ? 12'(pos[k] / ht) : 12'd0;
      clr = 1'b0;
      for (int j = 0; j <= LAT; j++)
        if (hr[k][(wp - 1 - j) % 16]) clr = 1'b1;
      e   = clr ? 28'h0 : hw[k][(wp - 1 - LAT) % 16];
      act = {req_a[k], x_a[k], y_a[k], dd_a[k], fs_a[k]};
      exp = {er, ex, ey, e[27:1], e[0]};
      n_chk++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model dut%0d cyc %0d: got %h expected %h",
                 k, cyc, act, exp);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (cyc >= 2) model_compare();
    @(posedge clk);
    #2;
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) step();
  endtask

  function automatic logic [63:0] evd(int k, int t, int i);
    return 64'(ev[k][t][i]);
  endfunction

  initial begin
    at_cycle(4);
    #1;
    chk("rst_dd_s", 64'(dd_a[0]), 64'h0);
    chk("rst_dd_l", 64'(dd_a[1]), 64'h0);
    chk("rst_req_s", 64'({req_a[0], fs_a[0]}), 64'h0);

    at_cycle(5);
    rst_a[0] = 1'b0;
    rst_a[1] = 1'b0;
    #1;
    chk("first_req_s", 64'({req_a[0], x_a[0], y_a[0]}), 64'h1000000);
    chk("first_req_l", 64'({req_a[1], x_a[1], y_a[1]}), 64'h1000000);

    at_cycle(8);
    #1;
    chk("fs_clk3_s", 64'(fs_a[0]), 64'h1);
    chk("fs_clk3_l", 64'(fs_a[1]), 64'h1);
    chk("px00_s", 64'(dd_a[0]), 64'h52C);
    chk("px00_l", 64'(dd_a[1]), 64'h52C);

    at_cycle(16);
    #1;
    chk("blank_fp_s", 64'(dd_a[0]), 64'h0);
    at_cycle(18);
    #1;
    chk("blank_hs_s", 64'(dd_a[0]), 64'h2);
    at_cycle(27);
    #1;
    chk("px31_s", 64'(dd_a[0]), 64'h180D2C);

    at_cycle(300);
    chk("s_nev", 64'((ne[0][6] >= 3) && (ne[0][0] >= 9)
                    && (ne[0][2] >= 18) && (ne[0][4] >= 1)), 64'h1);
    chk("s_fs0", evd(0, 6, 0), 64'd8);
    chk("s_de0", evd(0, 0, 0), 64'd8);
    chk("s_fper1", 64'(ev[0][6][1] - ev[0][6][0]), 64'd96);
    chk("s_fper2", 64'(ev[0][6][2] - ev[0][6][1]), 64'd96);
    for (int i = 0; i < 9; i++)
      chk("s_de_run", 64'(ev[0][1][i] - ev[0][0][i]), 64'd8);
    for (int i = 0; i < 18; i++)
      chk("s_hs_run", 64'(ev[0][3][i] - ev[0][2][i]), 64'd2);
    for (int i = 0; i < 17; i++)
      chk("s_line", 64'(ev[0][2][i+1] - ev[0][2][i]), 64'd16);
    chk("s_vs_pos", 64'(ev[0][4][0] - ev[0][6][0]), 64'd74);
    chk("s_vs_hs", evd(0, 4, 0), evd(0, 2, 4));
    chk("s_vs_w", 64'(ev[0][5][0] - ev[0][4][0]), 64'd16);

    at_cycle(388);
    rst_a[0] = 1'b1;
    #1;
    chk("wrap_rst_req", 64'({req_a[0], x_a[0], y_a[0]}), 64'h0);
    at_cycle(389);
    #1;
    chk("wrap_rst_dd", 64'({dd_a[0], fs_a[0]}), 64'h0);
    at_cycle(391);
    rst_a[0] = 1'b0;
    #1;
    chk("wrap_rel_req", 64'({req_a[0], x_a[0], y_a[0]}), 64'h1000000);
    at_cycle(394);
    #1;
    chk("wrap_rel_fs", 64'(fs_a[0]), 64'h1);
    chk("wrap_rel_dd", 64'(dd_a[0]), 64'h52C);

    at_cycle(4965);
    chk("l_nev", 64'((ne[1][2] >= 2) && (ne[1][0] >= 2)), 64'h1);
    chk("l_line", 64'(ev[1][2][1] - ev[1][2][0]), 64'd1650);
    chk("l_hs_w", 64'(ev[1][3][0] - ev[1][2][0]), 64'd40);
    chk("l_bp", 64'(ev[1][0][1] - ev[1][3][0]), 64'd220);
    chk("l_de_w", 64'(ev[1][1][0] - ev[1][0][0]), 64'd1280);

    at_cycle(17005);
    run_a[1] = 1'b0;
    #1;
    chk("drop_req", 64'(req_a[1]), 64'h0);
    at_cycle(17007);
    #1;
    chk("drop_last_px", 64'(dd_a[1]), 64'h798552C);
    at_cycle(17008);
    #1;
    chk("drop_drain", 64'(dd_a[1]), 64'h0);
    at_cycle(17025);
    run_a[1] = 1'b1;
    #1;
    chk("rerun_req", 64'({req_a[1], x_a[1], y_a[1]}), 64'h1000000);
    at_cycle(17027);
    #1;
    chk("rerun_fs_early", 64'(fs_a[1]), 64'h0);
    at_cycle(17028);
    #1;
    chk("rerun_fs", 64'(fs_a[1]), 64'h1);

    at_cycle(17040);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
